full_adder_bist_seq: RTL and testbench
======================================

# full_adder_bist_seq

Self-test sequencer for the 3-input full-adder gate block (inputs a, b, c; outputs f1 = sum, f2 = carry). Replaces the free-running stimulus module with a clocked controller: on start it drives all eight input vectors 000..111 in ascending order, holds each vector for a programmable settle time, and samples and checks f1/f2 against a golden model. It accumulates an error count and reports done/pass. It sits between the exercised full adder and the top-level test/status logic.

## Interface
- SETTLE_CYCLES, 4, cycles each vector is held before f1/f2 are sampled; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  level-sampled run request; accepted only in IDLE or DONE
- f1  input  1  sum output of the full adder under test
- f2  input  1  carry output of the full adder under test
- a, b, c  output  1 each  registered stimulus to the full adder; vector index = {a,b,c}
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until the next accepted start
- pass  output  1  high together with done when err_count == 0
- err_count  output  4  number of mismatching vectors in the last or current run, range 0..8
- first_fail  output  3  index of the first failing vector; meaningful only when err_count != 0

## Operation
- States:
  - IDLE: reset state.
  - RUN: vector sequencing.
  - DONE: results held.
- IDLE or DONE with start=1: at that edge, clear err_count, first_fail, done and pass; set busy=1; load vector 0 ({a,b,c}=000); load settle counter with SETTLE_CYCLES-1; go to RUN.
- RUN, counter != 0: decrement the counter and hold the vector.
- RUN, counter == 0 (sample edge):
  - Compare f1 against a^b^c and f2 against the majority of (a,b,c).
  - On any mismatch, increment err_count. If this is the first mismatch of the run, capture the vector index into first_fail.
  - If vector index < 7: load the next vector and reload the counter.
  - If vector index == 7: go to DONE, set busy=0, set done=1, set pass=(final err_count==0), and drive {a,b,c}=000.
- A vector counts as one error regardless of whether f1, f2 or both mismatch.
- start in RUN is ignored. There is no abort input.
- DONE holds all results until start.
- err_count cannot exceed 8; no saturation logic is needed.
- rst asserted at any time, including mid-run: immediately return to IDLE with all outputs at their reset values. A partial run leaves no residue.
- Reset values: a=b=c=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, state IDLE, counter 0.

## Timing
- Edge 0 is the edge that accepts start. From edge 0, the vector is 000.
- Vector k is driven from edge k·S to edge (k+1)·S, where S = SETTLE_CYCLES.
- f1/f2 for vector k are sampled at edge (k+1)·S. That same edge updates err_count and applies vector k+1.
- done, pass and busy=0 become visible after edge 8·S.
- f1/f2 are treated as combinational from a/b/c. S=1 is legal: the DUT has one full cycle to settle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- start held high continuously after DONE restarts the run on the next edge (back-to-back runs).

## Configuration
- FA_SEQ_FIRST_FAIL_EN defined: the first_fail capture register is built and behaves as described above.
- FA_SEQ_FIRST_FAIL_EN undefined: no capture register; first_fail is tied to 3'd0. All other behaviour is identical.

## Structure
- Package fa_bist_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the vector-count constant NUM_VECTORS = 8;
  - the golden function returning {carry, sum} for a 3-bit vector.
- One sub-module: fa_golden_check. It takes the combinational {a,b,c} and {f1,f2} and produces a 1-bit mismatch flag using the package function.
- The sequencer owns the state machine, settle counter, vector register and result registers.

## Test plan
- Correct full adder, S=4, start pulse:
  - busy rises after edge 0;
  - vectors step every 4 cycles;
  - after edge 32: done=1, pass=1, err_count=0, busy=0, {a,b,c}=000.
- f2 stuck at 0, S=4: failures on vectors 3, 5, 6, 7 → err_count=4, pass=0, first_fail=3 (first_fail=0 with the macro undefined).
- f1 inverted, S=1: all vectors fail → err_count=8, first_fail=0, done after edge 8.
- start pulsed again at vector 2 during a run: ignored; the run completes at the original edge 8·S with unchanged results.
- rst asserted while vector 4 is applied:
  - all outputs return to reset values asynchronously, with no clock edge required;
  - a subsequent start gives a full clean 8-vector run with pass=1.
- Faulty run to DONE (err_count=4), then start held high: the next edge clears done, pass and err_count, and a second run proceeds back-to-back.

Source files
------------

// File: rtl/fa_bist_pkg.sv
// Shared types and the golden full-adder model for the full-adder self-test sequencer.
package fa_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_VECTORS = 8;

    // Returns {carry, sum} for vector {a,b,c}.
    function automatic logic [1:0] fa_golden(input logic [2:0] vec);
        logic sum_bit;
        logic carry_bit;
        sum_bit   = ^vec;
        carry_bit = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
        return {carry_bit, sum_bit};
    endfunction

endpackage

// File: rtl/fa_golden_check.sv
// Flags a mismatch between the observed full-adder outputs and the golden model.
module fa_golden_check
    import fa_bist_pkg::*;
(
    input  logic [2:0] vec,
    input  logic       f1,
    input  logic       f2,
    output logic       mismatch
);

    assign mismatch = (fa_golden(vec) != {f2, f1});

endmodule

// File: rtl/full_adder_bist_seq.sv
// Clocked self-test sequencer: walks vectors 000..111, samples f1/f2 after a settle
// time and reports done/pass/err_count. Define FA_SEQ_FIRST_FAIL_EN to build first_fail capture.
module full_adder_bist_seq
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f1,
    input  logic       f2,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail
);

    localparam logic [7:0] RELOAD   = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_VEC = 3'(NUM_VECTORS - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       mismatch;
    logic       clr_run;
    logic       first_hit;

    fa_golden_check u_check (
        .vec      (vec_q),
        .f1       (f1),
        .f2       (f2),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        clr_run   = 1'b0;
        first_hit = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = RELOAD;
                    vec_d   = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    clr_run = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Sample edge: score this vector, then advance or finish.
                    err_d     = err_q + {3'b000, mismatch};
                    first_hit = mismatch && (err_q == 4'd0);
                    if (vec_q != LAST_VEC) begin
                        vec_d = vec_q + 3'd1;
                        cnt_d = RELOAD;
                    end else begin
                        state_d = DONE;
                        vec_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 4'd0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FA_SEQ_FIRST_FAIL_EN
    logic [2:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            ff_q <= '0;
        else if (clr_run)   ff_q <= '0;
        else if (first_hit) ff_q <= vec_q;
    end

    assign first_fail = ff_q;
`else
    logic unused_ff;
    assign unused_ff  = clr_run ^ first_hit;
    assign first_fail = 3'd0;
`endif

    assign {a, b, c}  = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_full_adder_bist_seq.sv
// Bench for full_adder_bist_seq: two instances (S=4, S=1) driven by a fault-injecting full-adder model.
module tb_full_adder_bist_seq;

`ifdef FA_SEQ_FIRST_FAIL_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, start1 = 1'b0;
    logic [7:0] m1 = '0, m2 = '0;   // per-vector fault masks on f1 / f2

    logic       a4, b4, c4, busy4, done4, pass4;
    logic [3:0] err4;
    logic [2:0] ff4;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] ff1;
    logic       f1_4, f2_4, f1_1, f2_1;

    int n_cmp = 0;
    int n_bad = 0;
    bit sel1  = 1'b0;

    always #5 clk = ~clk;

    // Full adder under test, with injectable per-vector faults.
    assign f1_4 = (a4 ^ b4 ^ c4) ^ m1[{a4, b4, c4}];
    assign f2_4 = ((a4 & b4) | (a4 & c4) | (b4 & c4)) ^ m2[{a4, b4, c4}];
    assign f1_1 = (a1 ^ b1 ^ c1) ^ m1[{a1, b1, c1}];
    assign f2_1 = ((a1 & b1) | (a1 & c1) | (b1 & c1)) ^ m2[{a1, b1, c1}];

    full_adder_bist_seq #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .f1(f1_4), .f2(f2_4),
        .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_fail(ff4)
    );

    full_adder_bist_seq #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .f1(f1_1), .f2(f2_1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1)
    );

    logic [2:0] vec_o;
    logic       busy_o, done_o, pass_o;
    logic [3:0] err_o;
    logic [2:0] ff_o;
    assign vec_o  = sel1 ? {a1, b1, c1} : {a4, b4, c4};
    assign busy_o = sel1 ? busy1 : busy4;
    assign done_o = sel1 ? done1 : done4;
    assign pass_o = sel1 ? pass1 : pass4;
    assign err_o  = sel1 ? err1 : err4;
    assign ff_o   = sel1 ? ff1 : ff4;

    typedef struct {
        bit         sel1;
        logic [7:0] m1;
        logic [7:0] m2;
        int         poke;      // edge after which start is pulsed mid-run (0 = none)
        int         exp_err;
        int         exp_ff;
        bit         exp_pass;
    } row_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_start(input bit v);
        if (sel1) start1 = v;
        else      start4 = v;
    endtask

    task automatic do_start();
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        chk("start_busy", busy_o, 1);
        chk("start_vec", vec_o, 0);
        chk("start_done_clr", done_o, 0);
    endtask

    // Follows a run from edge 0 to edge 8*S, checking vector stepping and final results.
    task automatic finish_run(input int poke, input int exp_err, input int exp_ff, input bit exp_pass);
        int s;
        s = sel1 ? 1 : 4;
        for (int e = 1; e <= 8 * s; e++) begin
            @(posedge clk);
            #1;
            set_start(1'b0);
            if (e == poke) set_start(1'b1);
            if (e < 8 * s && (e % s) == 0) begin
                chk("step_vec", vec_o, e / s);
                chk("step_busy", busy_o, 1);
                chk("step_done", done_o, 0);
            end
        end
        chk("end_done", done_o, 1);
        chk("end_busy", busy_o, 0);
        chk("end_pass", pass_o, exp_pass);
        chk("end_err", err_o, exp_err);
        chk("end_first_fail", ff_o, FF_EN ? exp_ff : 0);
        chk("end_vec", vec_o, 0);
    endtask

    // Reference: one error per vector with any fault; first_fail = lowest faulty index.
    task automatic model(input logic [7:0] fm1, input logic [7:0] fm2,
                         output int e_err, output int e_ff, output bit e_pass);
        logic [7:0] bad;
        bad   = fm1 | fm2;
        e_err = 0;
        e_ff  = -1;
        for (int k = 0; k < 8; k++) begin
            if (bad[k]) begin
                e_err++;
                if (e_ff < 0) e_ff = k;
            end
        end
        if (e_ff < 0) e_ff = 0;
        e_pass = (e_err == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        row_t rows[6];
        int   e_err, e_ff;
        bit   e_pass;

        rows[0] = '{1'b0, 8'h00, 8'h00, 0,  0, 0, 1'b1};  // clean, S=4
        rows[1] = '{1'b0, 8'h00, 8'hE8, 0,  4, 3, 1'b0};  // f2 stuck 0, S=4
        rows[2] = '{1'b1, 8'hFF, 8'h00, 0,  8, 0, 1'b0};  // f1 inverted, S=1
        rows[3] = '{1'b0, 8'h00, 8'h00, 9,  0, 0, 1'b1};  // start poked at vector 2
        rows[4] = '{1'b0, 8'h10, 8'h10, 0,  1, 4, 1'b0};  // both outputs wrong on one vector
        rows[5] = '{1'b1, 8'h00, 8'h81, 0,  2, 0, 1'b0};  // S=1 first and last

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vec4", {a4, b4, c4}, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_pass4", pass4, 0);
        chk("rst_err4", err4, 0);
        chk("rst_vec1", {a1, b1, c1}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", busy4, 0);

        for (int i = 0; i < 6; i++) begin
            sel1 = rows[i].sel1;
            m1   = rows[i].m1;
            m2   = rows[i].m2;
            do_start();
            finish_run(rows[i].poke, rows[i].exp_err, rows[i].exp_ff, rows[i].exp_pass);
        end

        // Randomized fault patterns against the reference model
        for (int i = 0; i < 8; i++) begin
            sel1 = i[0];
            m1   = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            m2   = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            if (i == 2) begin m1 = '0; m2 = '0; end
            model(m1, m2, e_err, e_ff, e_pass);
            do_start();
            finish_run(0, e_err, e_ff, e_pass);
        end

        // Asynchronous reset while vector 4 is applied, then a clean rerun
        sel1 = 1'b0;
        m1   = 8'h00;
        m2   = 8'hE8;
        do_start();
        repeat (16) @(posedge clk);
        #1;
        chk("pre_rst_vec", vec_o, 4);
        chk("pre_rst_err", err_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vec", vec_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_pass", pass_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_first_fail", ff_o, 0);
        @(negedge clk);
        rst = 1'b0;
        m2  = 8'h00;
        do_start();
        finish_run(0, 0, 0, 1'b1);

        // Faulty run then start held high: back-to-back restart
        m2 = 8'hE8;
        do_start();
        finish_run(0, 4, 3, 1'b0);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_done_clr", done_o, 0);
        chk("b2b_pass_clr", pass_o, 0);
        chk("b2b_err_clr", err_o, 0);
        chk("b2b_busy", busy_o, 1);
        chk("b2b_vec", vec_o, 0);
        m2 = 8'h00;
        finish_run(0, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
